// File: rtl/wbu_pkg.sv
// Shared definitions for the write-back / commit queue.
//   - CSR addresses decoded by the commit stage
//   - mcause code for an M-mode environment call
//   - mstatus bit positions for the MIE/MPIE/MPP stack
//   - per-entry control fields (XLEN-independent part of a queued op)
package wbu_pkg;

  localparam logic [11:0] CSR_MSTATUS   = 12'h300;
  localparam logic [11:0] CSR_MTVEC     = 12'h305;
  localparam logic [11:0] CSR_MEPC      = 12'h341;
  localparam logic [11:0] CSR_MCAUSE    = 12'h342;
  localparam logic [11:0] CSR_MCYCLE    = 12'hB00;
  localparam logic [11:0] CSR_MINSTRET  = 12'hB02;
  localparam logic [11:0] CSR_MCYCLEH   = 12'hB80;
  localparam logic [11:0] CSR_MINSTRETH = 12'hB82;

  localparam int MCAUSE_ECALL_M = 11;

  localparam int MSTATUS_MIE    = 3;
  localparam int MSTATUS_MPIE   = 7;
  localparam int MSTATUS_MPP_LO = 11;
  localparam int MSTATUS_MPP_HI = 12;

  // Control half of a commit entry; the XLEN-wide fields (pc, result,
  // csr_wdata) are concatenated alongside it by the parent.
  typedef struct packed {
    logic [4:0]  rd;
    logic        reg_wen;
    logic        csr_wen;
    logic [11:0] csr_addr;
    logic        ecall;
    logic        mret;
    logic        ebreak;
  } wbu_ctrl_t;

endpackage

// File: rtl/wbu_fifo.sv
// Synchronous FIFO with flush, used as the commit queue.
// Ports:
//   clk, rst_n      clock, synchronous active-low reset
//   i_push, i_data  enqueue request and data (ignored when full)
//   i_pop           dequeue head (ignored when empty)
//   i_flush         discard all entries; wins over a same-cycle push
//   o_head          current head entry (combinational)
//   o_full, o_empty occupancy flags
module wbu_fifo #(
  parameter int DEPTH = 2,
  parameter int WIDTH = 8
) (
  input  logic             clk,
  input  logic             rst_n,
  input  logic             i_push,
  input  logic [WIDTH-1:0] i_data,
  input  logic             i_pop,
  input  logic             i_flush,
  output logic [WIDTH-1:0] o_head,
  output logic             o_full,
  output logic             o_empty
);
  localparam int AW = $clog2(DEPTH);

  logic [WIDTH-1:0] r_mem [DEPTH];
  // Extra MSB is a wrap bit: equal pointers = empty, wrap bits differ = full.
  logic [AW:0]      r_wptr;
  logic [AW:0]      r_rptr;

  assign o_empty = (r_wptr == r_rptr);
  assign o_full  = (r_wptr[AW] != r_rptr[AW]) && (r_wptr[AW-1:0] == r_rptr[AW-1:0]);
  assign o_head  = r_mem[r_rptr[AW-1:0]];

  always_ff @(posedge clk) begin
    if (!rst_n || i_flush) begin
      r_wptr <= '0;
      r_rptr <= '0;
    end else begin
      if (i_push && !o_full)  r_wptr <= r_wptr + 1'b1;
      if (i_pop  && !o_empty) r_rptr <= r_rptr + 1'b1;
    end
  end

  // Storage needs no reset; pointers alone define validity.
  always_ff @(posedge clk) begin
    if (i_push && !o_full) r_mem[r_wptr[AW-1:0]] <= i_data;
  end

endmodule

// File: rtl/wbu_commit_queue.sv
// Write-back / commit stage with a DEPTH-entry queue, committing up to one op per cycle.
// Owns GPR write-back, the M-mode CSRs (mtvec, mepc, mcause, mstatus), mcycle/minstret,
// trap redirect (ecall/mret) with queue flush, and sticky ebreak halt.
// Ports:
//   clk, rst_n                       clock, synchronous active-low reset
//   in_*                             retired op from LSU (valid/ready handshake)
//   rf_wen/rf_waddr/rf_wdata         GPR write port
//   csr_raddr -> csr_rdata           combinational CSR read (pre-commit value)
//   exception_valid/target           one-cycle redirect to IFU
//   ebreak_flag                      sticky halt indicator
//   commit_valid/commit_pc           retirement trace
//   mcycle, minstret                 performance counters
module wbu_commit_queue
  import wbu_pkg::*;
#(
  parameter int              XLEN      = 32,
  parameter int              DEPTH     = 2,
  parameter int              CNT_W     = 64,
  parameter logic [XLEN-1:0] MTVEC_RST = 32'h8000_0000
) (
  input  logic             clk,
  input  logic             rst_n,
  input  logic             in_valid,
  output logic             in_ready,
  input  logic [XLEN-1:0]  in_pc,
  input  logic [XLEN-1:0]  in_result,
  input  logic [4:0]       in_rd,
  input  logic             in_reg_wen,
  input  logic             in_csr_wen,
  input  logic [11:0]      in_csr_addr,
  input  logic [XLEN-1:0]  in_csr_wdata,
  input  logic             in_ecall,
  input  logic             in_mret,
  input  logic             in_ebreak,
  output logic             rf_wen,
  output logic [4:0]       rf_waddr,
  output logic [XLEN-1:0]  rf_wdata,
  input  logic [11:0]      csr_raddr,
  output logic [XLEN-1:0]  csr_rdata,
  output logic             exception_valid,
  output logic [XLEN-1:0]  exception_target,
  output logic             ebreak_flag,
  output logic             commit_valid,
  output logic [XLEN-1:0]  commit_pc,
  output logic [CNT_W-1:0] mcycle,
  output logic [CNT_W-1:0] minstret
);
  localparam int CTRL_W  = $bits(wbu_ctrl_t);
  localparam int ENTRY_W = 3 * XLEN + CTRL_W;

  logic [XLEN-1:0]  r_mtvec, r_mepc, r_mcause, r_mstatus;
  logic [CNT_W-1:0] r_mcycle, r_minstret;
  logic             r_halted;

  wbu_ctrl_t        w_in_ctrl, w_head_ctrl;
  logic [ENTRY_W-1:0] w_in_entry, w_head;
  logic [XLEN-1:0]  w_head_pc, w_head_result, w_head_csr_wdata;
  logic             w_full, w_empty, w_commit, w_trap, w_push, w_flush;
  logic [XLEN-1:0]  w_mcycle_hi, w_minstret_hi;

  always_comb begin
    w_in_ctrl          = '0;
    w_in_ctrl.rd       = in_rd;
    w_in_ctrl.reg_wen  = in_reg_wen;
    w_in_ctrl.csr_wen  = in_csr_wen;
    w_in_ctrl.csr_addr = in_csr_addr;
    w_in_ctrl.ecall    = in_ecall;
    w_in_ctrl.mret     = in_mret;
    w_in_ctrl.ebreak   = in_ebreak;
  end

  assign w_in_entry       = {in_pc, in_result, in_csr_wdata, w_in_ctrl};
  assign w_head_pc        = w_head[ENTRY_W-1 -: XLEN];
  assign w_head_result    = w_head[ENTRY_W-XLEN-1 -: XLEN];
  assign w_head_csr_wdata = w_head[CTRL_W+XLEN-1 -: XLEN];
  assign w_head_ctrl      = wbu_ctrl_t'(w_head[CTRL_W-1:0]);

  // No commit while reset is asserted, even if stale entries are still queued.
  assign w_commit = rst_n && !w_empty && !r_halted;
  assign w_trap   = w_commit && (w_head_ctrl.ecall || w_head_ctrl.mret);
  assign w_flush  = w_trap || (w_commit && w_head_ctrl.ebreak);
  // Full queue does not accept even if the head pops this cycle.
  assign in_ready = !w_full && !r_halted && !w_trap;
  assign w_push   = in_valid && in_ready;

  wbu_fifo #(.DEPTH(DEPTH), .WIDTH(ENTRY_W)) u_fifo (
    .clk     (clk),
    .rst_n   (rst_n),
    .i_push  (w_push),
    .i_data  (w_in_entry),
    .i_pop   (w_commit),
    .i_flush (w_flush),
    .o_head  (w_head),
    .o_full  (w_full),
    .o_empty (w_empty)
  );

  assign commit_valid     = w_commit;
  assign commit_pc        = w_commit ? w_head_pc : '0;
  assign rf_wen           = w_commit && w_head_ctrl.reg_wen && (w_head_ctrl.rd != 5'd0);
  assign rf_waddr         = w_commit ? w_head_ctrl.rd : 5'd0;
  assign rf_wdata         = w_commit ? w_head_result : '0;
  assign exception_valid  = w_trap;
  assign exception_target = !w_trap ? '0 : (w_head_ctrl.ecall ? r_mtvec : r_mepc);
  assign ebreak_flag      = r_halted;
  assign mcycle           = r_mcycle;
  assign minstret         = r_minstret;

  // CSR file. Trap side effects are written after the explicit CSR write so
  // they take precedence for the same op.
  always_ff @(posedge clk) begin
    if (!rst_n) begin
      r_mtvec   <= MTVEC_RST;
      r_mepc    <= '0;
      r_mcause  <= '0;
      r_mstatus <= '0;
      r_halted  <= 1'b0;
    end else if (w_commit) begin
      if (w_head_ctrl.csr_wen) begin
        case (w_head_ctrl.csr_addr)
          CSR_MTVEC:   r_mtvec   <= w_head_csr_wdata;
          CSR_MEPC:    r_mepc    <= w_head_csr_wdata;
          CSR_MCAUSE:  r_mcause  <= w_head_csr_wdata;
          CSR_MSTATUS: r_mstatus <= w_head_csr_wdata;
          default:     ;
        endcase
      end
      if (w_head_ctrl.ecall) begin
        r_mepc                                  <= w_head_pc;
        r_mcause                                <= XLEN'(MCAUSE_ECALL_M);
        r_mstatus[MSTATUS_MPIE]                 <= r_mstatus[MSTATUS_MIE];
        r_mstatus[MSTATUS_MIE]                  <= 1'b0;
        r_mstatus[MSTATUS_MPP_HI:MSTATUS_MPP_LO] <= 2'b11;
      end
      if (w_head_ctrl.mret) begin
        r_mstatus[MSTATUS_MIE]  <= r_mstatus[MSTATUS_MPIE];
        r_mstatus[MSTATUS_MPIE] <= 1'b1;
      end
      if (w_head_ctrl.ebreak) r_halted <= 1'b1;
    end
  end

  always_ff @(posedge clk) begin
    if (!rst_n) begin
      r_mcycle   <= '0;
      r_minstret <= '0;
    end else begin
      r_mcycle   <= r_mcycle + 1'b1;
      r_minstret <= r_minstret + CNT_W'(w_commit);
    end
  end

  generate
    if (CNT_W > XLEN) begin : g_cnt_hi
      assign w_mcycle_hi   = XLEN'(r_mcycle[CNT_W-1:XLEN]);
      assign w_minstret_hi = XLEN'(r_minstret[CNT_W-1:XLEN]);
    end else begin : g_cnt_no_hi
      assign w_mcycle_hi   = '0;
      assign w_minstret_hi = '0;
    end
  endgenerate

  always_comb begin
    csr_rdata = '0;
    case (csr_raddr)
      CSR_MTVEC:     csr_rdata = r_mtvec;
      CSR_MEPC:      csr_rdata = r_mepc;
      CSR_MCAUSE:    csr_rdata = r_mcause;
      CSR_MSTATUS:   csr_rdata = r_mstatus;
      CSR_MCYCLE:    csr_rdata = r_mcycle[XLEN-1:0];
      CSR_MINSTRET:  csr_rdata = r_minstret[XLEN-1:0];
      CSR_MCYCLEH:   csr_rdata = w_mcycle_hi;
      CSR_MINSTRETH: csr_rdata = w_minstret_hi;
      default:       csr_rdata = '0;
    endcase
  end

endmodule

// File: tb/tb_wbu_commit_queue.sv
// Directed bench for wbu_commit_queue: streaming commits, rd=0 suppression,
// ecall/mret trap flow, CSR reads, ebreak halt and reset recovery.
module tb_wbu_commit_queue;
  logic        clk = 1'b0;
  logic        rst_n;
  logic        in_valid, in_ready;
  logic [31:0] in_pc, in_result, in_csr_wdata;
  logic [4:0]  in_rd;
  logic        in_reg_wen, in_csr_wen, in_ecall, in_mret, in_ebreak;
  logic [11:0] in_csr_addr, csr_raddr;
  logic        rf_wen;
  logic [4:0]  rf_waddr;
  logic [31:0] rf_wdata, csr_rdata, exception_target, commit_pc;
  logic        exception_valid, ebreak_flag, commit_valid;
  logic [63:0] mcycle, minstret;

  int n_checks = 0;
  int n_err    = 0;
  int exp_instret = 0;
  logic [63:0] exp_mcycle;

  always #5 clk = ~clk;

  // Reference cycle counter: zero during reset, +1 on every other edge.
  always @(posedge clk) exp_mcycle <= rst_n ? exp_mcycle + 64'd1 : 64'd0;

  wbu_commit_queue dut (
    .clk(clk), .rst_n(rst_n),
    .in_valid(in_valid), .in_ready(in_ready), .in_pc(in_pc), .in_result(in_result),
    .in_rd(in_rd), .in_reg_wen(in_reg_wen), .in_csr_wen(in_csr_wen),
    .in_csr_addr(in_csr_addr), .in_csr_wdata(in_csr_wdata),
    .in_ecall(in_ecall), .in_mret(in_mret), .in_ebreak(in_ebreak),
    .rf_wen(rf_wen), .rf_waddr(rf_waddr), .rf_wdata(rf_wdata),
    .csr_raddr(csr_raddr), .csr_rdata(csr_rdata),
    .exception_valid(exception_valid), .exception_target(exception_target),
    .ebreak_flag(ebreak_flag), .commit_valid(commit_valid), .commit_pc(commit_pc),
    .mcycle(mcycle), .minstret(minstret)
  );

  task automatic check(input string tag, input logic [63:0] obs, input logic [63:0] exp);
    n_checks++;
    assert (obs === exp) else begin
      n_err++;
      $error("FAIL %s observed=%0h expected=%0h", tag, obs, exp);
    end
  endtask

  task automatic tick;
    @(posedge clk);
    #1;
  endtask

  task automatic set_op(input logic [31:0] pc, input logic [31:0] res,
                        input logic [4:0] rd, input logic rwen);
    in_valid = 1'b1; in_pc = pc; in_result = res; in_rd = rd; in_reg_wen = rwen;
    in_csr_wen = 1'b0; in_csr_addr = 12'h0; in_csr_wdata = 32'h0;
    in_ecall = 1'b0; in_mret = 1'b0; in_ebreak = 1'b0;
  endtask

  task automatic set_csr(input logic [31:0] pc, input logic [11:0] addr, input logic [31:0] data);
    set_op(pc, 32'h0, 5'd0, 1'b0);
    in_csr_wen = 1'b1; in_csr_addr = addr; in_csr_wdata = data;
  endtask

  initial begin
    rst_n = 1'b0; csr_raddr = 12'h305;
    set_op(32'h0, 32'h0, 5'd0, 1'b0);
    in_valid = 1'b0;
    tick; tick;
    $display("step reset: held low");
    check("rst_mcycle", mcycle, 64'd0);
    check("rst_commit", {63'd0, commit_valid}, 64'd0);
    rst_n = 1'b1;
    tick;
    $display("step reset: released");
    check("rst_mtvec", {32'd0, csr_rdata}, 64'h8000_0000);
    check("rst_ready", {63'd0, in_ready}, 64'd1);
    check("rst_ebreak", {63'd0, ebreak_flag}, 64'd0);
    check("rst_exc", {63'd0, exception_valid}, 64'd0);
    check("rst_pc_zero", {32'd0, commit_pc}, 64'd0);
    check("rst_wdata_zero", {32'd0, rf_wdata}, 64'd0);
    check("rst_mcycle_run", mcycle, exp_mcycle);

    // 1. eight back-to-back ALU ops, one commit per cycle
    for (int k = 1; k <= 9; k++) begin
      if (k <= 8) set_op(32'h1000 + 32'(k) * 4, 32'(k) * 32'h11, 5'(k), 1'b1);
      else in_valid = 1'b0;
      #1;
      if (k >= 2) begin
        exp_instret++;
        $display("step stream: commit op %0d", k - 1);
        check("s1_cv", {63'd0, commit_valid}, 64'd1);
        check("s1_wen", {63'd0, rf_wen}, 64'd1);
        check("s1_waddr", {59'd0, rf_waddr}, 64'(k - 1));
        check("s1_wdata", {32'd0, rf_wdata}, 64'((k - 1) * 32'h11));
        check("s1_pc", {32'd0, commit_pc}, 64'(32'h1000 + (k - 1) * 4));
      end else begin
        check("s1_cv_first", {63'd0, commit_valid}, 64'd0);
      end
      if (k <= 8) check("s1_ready", {63'd0, in_ready}, 64'd1);
      tick;
    end
    csr_raddr = 12'hB02; #1;
    $display("step stream: minstret read");
    check("s1_minstret", {32'd0, csr_rdata}, 64'd8);
    check("s1_idle_cv", {63'd0, commit_valid}, 64'd0);

    // 2. rd=0 write is suppressed but still commits
    set_op(32'h2000, 32'hDEAD_BEEF, 5'd0, 1'b1);
    tick; in_valid = 1'b0; #1;
    exp_instret++;
    $display("step rd0");
    check("s2_cv", {63'd0, commit_valid}, 64'd1);
    check("s2_wen", {63'd0, rf_wen}, 64'd0);
    check("s2_pc", {32'd0, commit_pc}, 64'h2000);
    tick;

    // 3. csrw mstatus.MIE, csrw mtvec, ecall (with a same-op mcause write that the trap overrides)
    set_csr(32'h8000_0040, 12'h300, 32'h8); tick;
    set_csr(32'h8000_0044, 12'h305, 32'h8000_1000); #1;
    exp_instret++;
    check("s3_cv_mstatus", {63'd0, commit_valid}, 64'd1);
    tick;
    set_csr(32'h8000_0100, 12'h342, 32'h5); in_ecall = 1'b1;
    csr_raddr = 12'h305; #1;
    exp_instret++;
    $display("step ecall: mtvec commit, no forwarding");
    check("s3_mtvec_old", {32'd0, csr_rdata}, 64'h8000_0000);
    tick;
    set_op(32'h8000_0104, 32'h99, 5'd9, 1'b1); #1;
    exp_instret++;
    $display("step ecall: trap cycle");
    check("s3_exc", {63'd0, exception_valid}, 64'd1);
    check("s3_target", {32'd0, exception_target}, 64'h8000_1000);
    check("s3_pc", {32'd0, commit_pc}, 64'h8000_0100);
    check("s3_ready", {63'd0, in_ready}, 64'd0);
    tick;
    in_valid = 1'b0; csr_raddr = 12'h341; #1;
    check("s3_younger_dropped", {63'd0, commit_valid}, 64'd0);
    check("s3_exc_pulse", {63'd0, exception_valid}, 64'd0);
    check("s3_mepc", {32'd0, csr_rdata}, 64'h8000_0100);
    csr_raddr = 12'h342; #1;
    check("s3_mcause", {32'd0, csr_rdata}, 64'd11);
    csr_raddr = 12'h300; #1;
    check("s3_mstatus", {32'd0, csr_rdata}, 64'h1880);
    tick;
    check("s3_still_idle", {63'd0, commit_valid}, 64'd0);

    // 4. csrw mepc, then mret
    set_csr(32'h8000_0108, 12'h341, 32'h8000_0104); tick;
    set_op(32'h8000_010C, 32'h0, 5'd0, 1'b0); in_mret = 1'b1; #1;
    exp_instret++;
    check("s4_cv_mepc", {63'd0, commit_valid}, 64'd1);
    tick;
    in_valid = 1'b0; #1;
    exp_instret++;
    $display("step mret: trap cycle");
    check("s4_exc", {63'd0, exception_valid}, 64'd1);
    check("s4_target", {32'd0, exception_target}, 64'h8000_0104);
    check("s4_pc", {32'd0, commit_pc}, 64'h8000_010C);
    tick;
    csr_raddr = 12'h300; #1;
    check("s4_mstatus", {32'd0, csr_rdata}, 64'h1888);
    csr_raddr = 12'h123; #1;
    check("s4_unknown", {32'd0, csr_rdata}, 64'd0);
    csr_raddr = 12'hB80; #1;
    check("s4_mcycleh", {32'd0, csr_rdata}, 64'd0);

    // 5. held valid stream: each op commits exactly once, in order
    for (int k = 0; k <= 3; k++) begin
      if (k <= 2) set_op(32'h3000 + 32'(k) * 4, 32'h500 + 32'(k), 5'(20 + k), 1'b1);
      else in_valid = 1'b0;
      #1;
      if (k >= 1) begin
        exp_instret++;
        $display("step held: commit rd %0d", 19 + k);
        check("s5_cv", {63'd0, commit_valid}, 64'd1);
        check("s5_waddr", {59'd0, rf_waddr}, 64'(19 + k));
      end
      tick;
    end
    check("s5_no_dup", {63'd0, commit_valid}, 64'd0);

    // 6. ebreak halts; later ops are refused, mcycle keeps counting
    set_op(32'h8000_0200, 32'h0, 5'd0, 1'b0); in_ebreak = 1'b1; tick;
    set_op(32'h8000_0204, 32'h77, 5'd10, 1'b1); #1;
    exp_instret++;
    $display("step ebreak: commit");
    check("s6_cv", {63'd0, commit_valid}, 64'd1);
    check("s6_pc", {32'd0, commit_pc}, 64'h8000_0200);
    check("s6_flag_late", {63'd0, ebreak_flag}, 64'd0);
    check("s6_exc", {63'd0, exception_valid}, 64'd0);
    tick;
    for (int k = 0; k < 3; k++) begin
      $display("step ebreak: halted cycle %0d", k);
      check("s6_flag", {63'd0, ebreak_flag}, 64'd1);
      check("s6_ready", {63'd0, in_ready}, 64'd0);
      check("s6_cv_halt", {63'd0, commit_valid}, 64'd0);
      tick;
    end
    csr_raddr = 12'hB00; #1;
    check("s6_mcycle", mcycle, exp_mcycle);
    check("s6_mcycle_csr", {32'd0, csr_rdata}, {32'd0, exp_mcycle[31:0]});
    check("s6_minstret", minstret, 64'(exp_instret));
    check("s6_minstret_18", minstret, 64'd18);

    // reset for one cycle
    rst_n = 1'b0; tick; rst_n = 1'b1; in_valid = 1'b0;
    csr_raddr = 12'h305; #1;
    $display("step reset again");
    check("r2_flag", {63'd0, ebreak_flag}, 64'd0);
    check("r2_ready", {63'd0, in_ready}, 64'd1);
    check("r2_mcycle", mcycle, 64'd0);
    check("r2_minstret", minstret, 64'd0);
    check("r2_mtvec", {32'd0, csr_rdata}, 64'h8000_0000);
    csr_raddr = 12'h300; #1;
    check("r2_mstatus", {32'd0, csr_rdata}, 64'd0);
    check("r2_cv", {63'd0, commit_valid}, 64'd0);
    tick;
    check("r2_mcycle_run", mcycle, 64'd1);

    $display("Result: errors=%0d of %0d checks", n_err, n_checks);
    $finish;
  end
endmodule
